// File: rtl/erasure_locator_polyn.sv
// Erasure locator polynomial builder over GF(2^8) (primitive poly 0x11D).
//
// Folds a stream of erasure locators X_i into sigma(x) = prod(1 + X_i*x),
// updating one coefficient per clock in place. A zero locator marks a
// symbol that was not erased and leaves sigma untouched. The finished
// polynomial is read out by coefficient index with one cycle of latency.
//
// Ports
//   clock_i          clock, all logic on the rising edge
//   reset_i          synchronous active-high reset
//   start_i          pulse: clear sigma to 1 and begin a new codeword
//   erasure_valid_i  erasure_value_i / erasure_last_i valid this cycle
//   erasure_value_i  locator X_i, 8'd0 = symbol not erased
//   erasure_last_i   with erasure_valid_i: final symbol of the codeword
//   in_ready_o       high only while idle; transfer = valid & ready
//   coef_addr_i      sigma coefficient index for readout
//   coef_data_o      registered sigma[coef_addr_i] (0 when out of range)
//   erasure_count_o  number of nonzero locators folded in (saturating)
//   overflow_o       sticky: nonzero locator arrived with count at maximum
//   poly_valid_o     sigma complete
module erasure_locator_polyn #(
  parameter int unsigned MAX_ERASURES = 32
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       erasure_valid_i,
  input  logic [7:0] erasure_value_i,
  input  logic       erasure_last_i,
  output logic       in_ready_o,
  input  logic [5:0] coef_addr_i,
  output logic [7:0] coef_data_o,
  output logic [5:0] erasure_count_o,
  output logic       overflow_o,
  output logic       poly_valid_o
);

  localparam int unsigned AW   = $clog2(MAX_ERASURES + 1);
  localparam logic [5:0]  MAX6 = 6'(MAX_ERASURES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  sigma_q [0:MAX_ERASURES];
  logic [5:0]  j_q;
  logic [7:0]  x_q;
  logic        last_q;
  logic [5:0]  count_q;
  logic        overflow_q;
  logic [7:0]  coef_q;

  logic [5:0]    jm1_d;
  logic [AW-1:0] j_idx_d;
  logic [AW-1:0] prev_idx_d;
  logic [7:0]    prod_d;

  // GF(2^8) multiply, shift-and-add with reduction by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // Single shared multiplier: X * sigma[j-1]. Walking j downward keeps
  // sigma[j-1] at its pre-update value when sigma[j] is rewritten.
  always_comb begin
    jm1_d      = j_q - 6'd1;
    j_idx_d    = j_q[AW-1:0];
    prev_idx_d = (j_q == '0) ? '0 : jm1_d[AW-1:0];
    prod_d     = gf_mul(x_q, sigma_q[prev_idx_d]);
  end

  always_ff @(posedge clock_i) begin
    // Readout runs every cycle in every state; reset alone clears it.
    if (reset_i) begin
      coef_q <= '0;
    end else if (coef_addr_i <= MAX6) begin
      coef_q <= sigma_q[coef_addr_i[AW-1:0]];
    end else begin
      coef_q <= '0;
    end

    if (reset_i || start_i) begin
      state_q    <= S_IDLE;
      for (int unsigned i = 0; i <= MAX_ERASURES; i++) begin
        sigma_q[i] <= (i == 0) ? 8'h01 : 8'h00;
      end
      j_q        <= '0;
      x_q        <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (erasure_valid_i) begin
            if (erasure_value_i == '0) begin
              if (erasure_last_i) state_q <= S_DONE;
            end else if (count_q == MAX6) begin
              overflow_q <= 1'b1;
              if (erasure_last_i) state_q <= S_DONE;
            end else begin
              x_q     <= erasure_value_i;
              j_q     <= count_q + 6'd1;
              last_q  <= erasure_last_i;
              state_q <= S_UPDATE;
            end
          end
        end

        S_UPDATE: begin
          sigma_q[j_idx_d] <= sigma_q[j_idx_d] ^ prod_d;
          j_q              <= jm1_d;
          // Count is committed only on the final coefficient so an abort
          // mid-update never leaves a partial increment.
          if (j_q == 6'd1) begin
            if (count_q != MAX6) count_q <= count_q + 6'd1;
            state_q <= last_q ? S_DONE : S_IDLE;
          end
        end

        S_DONE: begin
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o      = (state_q == S_IDLE);
  assign poly_valid_o    = (state_q == S_DONE);
  assign coef_data_o     = coef_q;
  assign erasure_count_o = count_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_erasure_locator_polyn.sv
module tb_erasure_locator_polyn;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] value;
  logic       last;
  logic [5:0] addr;

  logic       ready,  ready4;
  logic [7:0] data,   data4;
  logic [5:0] count,  count4;
  logic       ovf,    ovf4;
  logic       pv,     pv4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  erasure_locator_polyn u_dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .erasure_valid_i(valid),
    .erasure_value_i(value),
    .erasure_last_i (last),
    .in_ready_o     (ready),
    .coef_addr_i    (addr),
    .coef_data_o    (data),
    .erasure_count_o(count),
    .overflow_o     (ovf),
    .poly_valid_o   (pv)
  );

  erasure_locator_polyn #(.MAX_ERASURES(4)) u_dut4 (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .erasure_valid_i(valid),
    .erasure_value_i(value),
    .erasure_last_i (last),
    .in_ready_o     (ready4),
    .coef_addr_i    (addr),
    .coef_data_o    (data4),
    .erasure_count_o(count4),
    .overflow_o     (ovf4),
    .poly_valid_o   (pv4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the selected DUT to be ready, then transfers one symbol.
  task automatic send(input logic [7:0] v, input logic l, input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? ready : ready4) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 8'(n < 200), 8'd1);
    valid = 1'b1;
    value = v;
    last  = l;
    @(negedge clk);
    valid = 1'b0;
    value = '0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? pv : pv4) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 8'(n < 200), 8'd1);
  endtask

  task automatic rd(input int sel, input logic [5:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    @(negedge clk);
    chk(tag, (sel == 0) ? data : data4, exp);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    value = '0;
    last  = 1'b0;
    addr  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready",  8'(ready), 8'd1);
    chk("rst_pv",     8'(pv),    8'd0);
    chk("rst_count",  8'(count), 8'd0);
    chk("rst_ovf",    8'(ovf),   8'd0);
    chk("rst_coef",   data,      8'h00);
    rst = 1'b0;
    rd(0, 6'd0, 8'h01, "rst_sigma0");
    rd(0, 6'd1, 8'h00, "rst_sigma1");

    // 1) single erasure X=02
    pulse_start();
    send(8'h02, 1'b1, 0);
    chk("t1_busy_ready", 8'(ready), 8'd0);
    chk("t1_busy_pv",    8'(pv),    8'd0);
    @(negedge clk);
    chk("t1_pv",    8'(pv),    8'd1);
    chk("t1_count", 8'(count), 8'd1);
    rd(0, 6'd0, 8'h01, "t1_s0");
    rd(0, 6'd1, 8'h02, "t1_s1");
    rd(0, 6'd2, 8'h00, "t1_s2");
    valid = 1'b1; value = 8'h04; last = 1'b1;
    @(negedge clk);
    valid = 1'b0; value = '0; last = 1'b0;
    @(negedge clk);
    chk("t1_done_ignore", 8'(count), 8'd1);

    // 2) X=02 then X=04: second update takes two cycles
    pulse_start();
    send(8'h02, 1'b0, 0);
    send(8'h04, 1'b1, 0);
    chk("t2_upd_ready0", 8'(ready), 8'd0);
    @(negedge clk);
    chk("t2_upd_ready1", 8'(ready), 8'd0);
    chk("t2_upd_pv1",    8'(pv),    8'd0);
    @(negedge clk);
    chk("t2_pv",    8'(pv),    8'd1);
    chk("t2_count", 8'(count), 8'd2);
    rd(0, 6'd0, 8'h01, "t2_s0");
    rd(0, 6'd1, 8'h06, "t2_s1");
    rd(0, 6'd2, 8'h08, "t2_s2");
    rd(0, 6'd3, 8'h00, "t2_s3");

    // 3) X=80 twice: exercises the 0x11D reduction (80*80 = 13)
    pulse_start();
    send(8'h80, 1'b0, 0);
    send(8'h80, 1'b1, 0);
    wait_done(0);
    chk("t3_count", 8'(count), 8'd2);
    rd(0, 6'd0, 8'h01, "t3_s0");
    rd(0, 6'd1, 8'h00, "t3_s1");
    rd(0, 6'd2, 8'h13, "t3_s2");

    // 4) ten non-erased symbols
    pulse_start();
    for (int i = 0; i < 9; i++) send(8'h00, 1'b0, 0);
    chk("t4_ready_mid", 8'(ready), 8'd1);
    chk("t4_pv_mid",    8'(pv),    8'd0);
    send(8'h00, 1'b1, 0);
    chk("t4_pv",    8'(pv),    8'd1);
    chk("t4_count", 8'(count), 8'd0);
    rd(0, 6'd0, 8'h01, "t4_s0");
    rd(0, 6'd1, 8'h00, "t4_s1");

    // 5) MAX_ERASURES=4 instance, five nonzero locators
    pulse_start();
    send(8'h02, 1'b0, 1);
    send(8'h04, 1'b0, 1);
    send(8'h08, 1'b0, 1);
    send(8'h10, 1'b0, 1);
    send(8'h20, 1'b1, 1);
    wait_done(1);
    chk("t5_ovf",   8'(ovf4),   8'd1);
    chk("t5_count", 8'(count4), 8'd4);
    rd(1, 6'd0, 8'h01, "t5_s0");
    rd(1, 6'd1, 8'h1E, "t5_s1");
    rd(1, 6'd2, 8'hD8, "t5_s2");
    rd(1, 6'd3, 8'hE7, "t5_s3");
    rd(1, 6'd4, 8'h74, "t5_s4");
    rd(1, 6'd5, 8'h00, "t5_addr_oor");
    wait_done(0);
    chk("t5_big_count", 8'(count), 8'd5);
    chk("t5_big_ovf",   8'(ovf),   8'd0);

    // 6) reset mid-update, then start with a same-cycle erasure
    pulse_start();
    send(8'h02, 1'b0, 0);
    send(8'h04, 1'b0, 0);
    send(8'h08, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_ready", 8'(ready), 8'd1);
    chk("t6_count", 8'(count), 8'd0);
    chk("t6_pv",    8'(pv),    8'd0);
    rd(0, 6'd0, 8'h01, "t6_s0");
    rd(0, 6'd1, 8'h00, "t6_s1");
    rd(0, 6'd2, 8'h00, "t6_s2");
    start = 1'b1; valid = 1'b1; value = 8'h02; last = 1'b1;
    @(negedge clk);
    start = 1'b0; valid = 1'b0; value = '0; last = 1'b0;
    chk("t6_drop_ready", 8'(ready), 8'd1);
    chk("t6_drop_pv",    8'(pv),    8'd0);
    @(negedge clk);
    chk("t6_drop_count", 8'(count), 8'd0);
    rd(0, 6'd1, 8'h00, "t6_drop_s1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
